// File: rtl/rpatrol_pkg.sv
// Shared River Patrol definitions: loader FSM states and game ROM image geometry.
package rpatrol_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        HOLD,
        RUN
    } loader_state_t;

    localparam int unsigned RPATROL_ROM_BYTES = 32'h0000_A000;
    localparam logic [7:0]  RPATROL_ROM_INDEX = 8'd0;

endpackage

// File: rtl/edge_detect.sv
// Level edge detector: registers a level and flags rise/fall against the registered copy.
// Latency: pulses are combinational in the cycle the new level is first seen.
// Backpressure: none, pure observer.
module edge_detect #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic level_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= RESET_LEVEL;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/rpatrol_rom_loader.sv
// Filters the HPS ioctl stream to the game ROM, re-times it onto dn_*, checks size, gates core reset.
// Latency: ioctl_wr to dn_wr is 1 cycle; core released HOLD_CYCLES+2 cycles after download falls.
// Backpressure: none, accepts one byte per cycle at full rate.
module rpatrol_rom_loader
    import rpatrol_pkg::*;
#(
    parameter int unsigned ROM_BYTES   = RPATROL_ROM_BYTES,
    parameter logic [7:0]  ROM_INDEX   = RPATROL_ROM_INDEX,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [16:0] byte_count
);

    localparam logic [24:0] ROM_LIMIT = 25'(ROM_BYTES);
    localparam logic [16:0] ROM_SIZE  = 17'(ROM_BYTES);
    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);

    loader_state_t state, state_nxt;
    logic [15:0]   hold_cnt;
    logic          dl_rise, dl_fall;
    logic          start;
    logic          wr_ok;
    logic          wr_bad;

    // Reset level high: a download already running when reset releases must not look like a new start.
    edge_detect #(
        .RESET_LEVEL (1'b1)
    ) u_dl_edge (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .level   (ioctl_download),
        .rise    (dl_rise),
        .fall    (dl_fall)
    );

    assign start = dl_rise && (ioctl_index == ROM_INDEX);

    always_comb begin
        state_nxt = state;
        wr_ok     = 1'b0;
        wr_bad    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if (ioctl_wr) begin
                    if ((ioctl_addr < ROM_LIMIT) && (ioctl_addr == {8'd0, byte_count})) begin
                        wr_ok = 1'b1;
                    end else begin
                        wr_bad = 1'b1;
                    end
                end
                if (dl_fall) state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = start ? LOAD : HOLD;
            end
            HOLD: begin
                if (start) begin
                    state_nxt = LOAD;
                end else if (hold_cnt == 16'd0) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dn_addr    <= 16'd0;
            dn_data    <= 8'd0;
            dn_wr      <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            byte_count <= 17'd0;
            hold_cnt   <= 16'd0;
        end else begin
            dn_wr <= 1'b0;
            if ((state_nxt == LOAD) && (state != LOAD)) begin
                load_done  <= 1'b0;
                load_err   <= 1'b0;
                byte_count <= 17'd0;
            end else begin
                if (wr_ok) begin
                    dn_addr    <= ioctl_addr[15:0];
                    dn_data    <= ioctl_dout;
                    dn_wr      <= 1'b1;
                    byte_count <= byte_count + 17'd1;
                end
                if (wr_bad) load_err <= 1'b1;
                if ((state == CHECK) && (byte_count != ROM_SIZE)) load_err <= 1'b1;
                // Core runs even on a bad image; only a clean load reports done.
                if ((state == HOLD) && (state_nxt == RUN) && !load_err) load_done <= 1'b1;
            end
            if (state == CHECK) begin
                hold_cnt <= HOLD_INIT;
            end else if ((state == HOLD) && (hold_cnt != 16'd0)) begin
                hold_cnt <= hold_cnt - 16'd1;
            end
        end
    end

    assign core_reset = (state != RUN);

endmodule

// File: tb/tb_rpatrol_rom_loader.sv
// Bench for rpatrol_rom_loader: per-cycle reference model plus a table of whole-download scenarios.
module tb_rpatrol_rom_loader;
    import rpatrol_pkg::*;

    localparam int ROM  = 32'hA000;
    localparam int HOLD = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_reset;
    logic        load_done;
    logic        load_err;
    logic [16:0] byte_count;

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    rpatrol_rom_loader dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .load_err       (load_err),
        .byte_count     (byte_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a session is "loading" from a matching start until download falls;
    // the size check lands one cycle after the fall and the core runs HOLD+2 cycles after it.
    int          cyc = 0;
    bit          m_prev_dl = 1'b1;
    bit          m_loading = 1'b0;
    int          m_bc = 0;
    bit          m_err = 1'b0;
    bit          m_done = 1'b0;
    bit          m_cr = 1'b1;
    bit          m_wr = 1'b0;
    logic [15:0] m_addr = 16'd0;
    logic [7:0]  m_data = 8'd0;
    int          m_fall = -1;
    bit          mon_en = 1'b0;

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_prev_dl = 1'b1;
            m_loading = 1'b0;
            m_bc = 0; m_err = 1'b0; m_done = 1'b0; m_cr = 1'b1;
            m_wr = 1'b0; m_addr = 16'd0; m_data = 8'd0; m_fall = -1;
        end else begin
            bit rise, fall;
            cyc++;
            rise = ioctl_download && !m_prev_dl;
            fall = !ioctl_download && m_prev_dl;
            m_prev_dl = ioctl_download;
            m_wr = 1'b0;
            if (rise && ioctl_index == RPATROL_ROM_INDEX) begin
                m_loading = 1'b1; m_bc = 0; m_err = 1'b0; m_done = 1'b0; m_cr = 1'b1; m_fall = -1;
            end else if (m_loading) begin
                if (ioctl_wr) begin
                    if (int'(ioctl_addr) < ROM && int'(ioctl_addr) == m_bc) begin
                        m_wr = 1'b1; m_addr = ioctl_addr[15:0]; m_data = ioctl_dout; m_bc++;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (fall) begin
                    m_loading = 1'b0;
                    m_fall = cyc;
                end
            end else if (m_fall >= 0) begin
                if (cyc == m_fall + 1 && m_bc != ROM) m_err = 1'b1;
                if (cyc == m_fall + HOLD + 1) begin
                    m_cr = 1'b0; m_done = !m_err; m_fall = -1;
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        if (mon_en) begin
            check("dn_wr", dn_wr, m_wr);
            if (m_wr) begin
                check("dn_addr", dn_addr, m_addr);
                check("dn_data", dn_data, m_data);
            end
            check("byte_count", byte_count, m_bc);
            check("load_err", load_err, m_err);
            check("load_done", load_done, m_done);
            check("core_reset", core_reset, m_cr);
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dn_addr"}, dn_addr, 0);
        check({tag, "_dn_data"}, dn_data, 0);
        check({tag, "_dn_wr"}, dn_wr, 0);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_load_err"}, load_err, 0);
        check({tag, "_byte_count"}, byte_count, 0);
    endtask

    // Falls the download and measures cycles until the core is released.
    task automatic finish_and_time(input string tag, input bit exp_done);
        int n;
        ioctl_download = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (core_reset && n < 100);
        check({tag, "_release_cycles"}, n, HOLD + 2);
        check({tag, "_done_at_release"}, load_done, exp_done);
    endtask

    typedef struct {
        logic [7:0]  idx;
        int          nbytes;
        bit          bad_en;
        logic [24:0] bad_addr;
        int          exp_bc;
        bit          exp_err;
        bit          exp_done;
        bit          exp_cr;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] ridx;
    int r;

    initial begin
        tbl[0] = '{8'd0, 0,     1'b1, 25'h100_0000, 0,     1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'd0, 3,     1'b1, 25'h000_A000, 3,     1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'd0, 3,     1'b1, 25'd5,        3,     1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'd0, 40000, 1'b0, 25'd0,        40000, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'd0, 40960, 1'b0, 25'd0,        40960, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'd1, 100,   1'b0, 25'd0,        40960, 1'b0, 1'b1, 1'b0};

        #1;
        check_reset_values("por");
        #20;
        reset_n = 1'b1;
        tick();
        mon_en = 1'b1;
        repeat (3) tick();
        check("idle_core_reset", core_reset, 1);

        for (int t = 0; t < 6; t++) begin
            ioctl_index = tbl[t].idx;
            ioctl_download = 1'b1;
            tick();
            for (int i = 0; i < tbl[t].nbytes; i++) wr_byte(25'(i), 8'($urandom));
            if (tbl[t].bad_en) begin
                wr_byte(tbl[t].bad_addr, 8'hEE);
                check($sformatf("t%0d_bad_no_wr", t), dn_wr, 0);
                check($sformatf("t%0d_bad_err", t), load_err, 1);
                check($sformatf("t%0d_bad_bc", t), byte_count, tbl[t].nbytes);
            end
            if (tbl[t].idx == RPATROL_ROM_INDEX) begin
                finish_and_time($sformatf("t%0d", t), tbl[t].exp_done);
            end else begin
                ioctl_download = 1'b0;
                repeat (HOLD + 4) tick();
            end
            check($sformatf("t%0d_bc", t), byte_count, tbl[t].exp_bc);
            check($sformatf("t%0d_err", t), load_err, tbl[t].exp_err);
            check($sformatf("t%0d_done", t), load_done, tbl[t].exp_done);
            check($sformatf("t%0d_core_reset", t), core_reset, tbl[t].exp_cr);
            tick();
        end

        // Reload while running.
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        tick();
        check("reload_core_reset", core_reset, 1);
        check("reload_done", load_done, 0);
        check("reload_err", load_err, 0);
        check("reload_bc", byte_count, 0);

        // Random sessions, including restarts landing in CHECK/HOLD and foreign downloads.
        for (int s = 0; s < 6; s++) begin
            if (s > 0) begin
                ridx = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
                ioctl_index = ridx;
                ioctl_download = 1'b1;
                tick();
            end
            for (int c = 0; c < 300; c++) begin
                r = $urandom_range(0, 9);
                if (r < 6) begin
                    wr_byte(25'(m_bc), 8'($urandom));
                end else if (r == 6) begin
                    wr_byte((m_bc > 0 && $urandom_range(0, 1) == 1) ? 25'(m_bc - 1)
                                                                   : 25'(m_bc + $urandom_range(1, 4)),
                            8'($urandom));
                end else if (r == 7) begin
                    wr_byte(25'($urandom), 8'($urandom));
                end else begin
                    tick();
                end
            end
            ioctl_download = 1'b0;
            repeat ($urandom_range(1, HOLD + 3)) tick();
        end
        repeat (HOLD + 4) tick();

        // Reset in the middle of a download; the rest of it must be ignored.
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 1000; i++) wr_byte(25'(i), 8'($urandom));
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        tick();
        tick();
        #2;
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            wr_byte(25'(i), 8'($urandom));
            check("midrst_no_wr", dn_wr, 0);
        end
        check("midrst_bc", byte_count, 0);
        ioctl_download = 1'b0;
        repeat (HOLD + 4) tick();
        check("midrst_still_reset", core_reset, 1);
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) wr_byte(25'(i), 8'($urandom));
        check("fresh_bc", byte_count, 16);
        finish_and_time("fresh", 1'b0);
        check("fresh_err", load_err, 1);
        repeat (4) tick();

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
